// File: rtl/fir_filter.sv
// Direct-form FIR: a tapped delay line of signed samples and a single-cycle
// combinational multiply-accumulate tree that produces the exact convolution.
module fir_filter #(
  parameter int TAPS = 8,
  parameter logic [TAPS*16-1:0] COEFFS = {16'd1, 16'd2, 16'd3, 16'd4,
                                          16'd4, 16'd3, 16'd2, 16'd1}
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ena,
  input  logic signed [15:0] sample,
  output logic signed [38:0] out
);

  logic signed [15:0] x [TAPS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < TAPS; k++) x[k] <= '0;
    end else if (ena) begin
      x[0] <= sample;
      for (int k = 1; k < TAPS; k++) x[k] <= x[k-1];
    end
  end

  // 39 bits leave headroom for 128 full-scale 32-bit products, so no wrap.
  logic signed [31:0] prod;
  logic signed [38:0] acc;

  always_comb begin
    acc  = '0;
    prod = '0;
    for (int k = 0; k < TAPS; k++) begin
      prod = x[k] * $signed(COEFFS[k*16 +: 16]);
      acc  = acc + {{7{prod[31]}}, prod};
    end
  end

  assign out = acc;

endmodule

// File: tb/tb_fir_filter.sv
// Randomised and directed checks of fir_filter against a sample-history model.
module tb_fir_filter;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               ena = 1'b0;
  logic signed [15:0] sample = '0;
  logic signed [38:0] out;

  logic               ena_w = 1'b0;
  logic signed [15:0] sample_w = '0;
  logic signed [38:0] out_w;

  int errors = 0;
  int checks = 0;

  int     coef [8] = '{1, 2, 3, 4, 4, 3, 2, 1};
  longint hist [8];

  always #5 clk = ~clk;

  fir_filter dut (
    .clk(clk), .rst(rst), .ena(ena), .sample(sample), .out(out)
  );

  fir_filter #(
    .TAPS(128),
    .COEFFS({128{16'h8000}})
  ) dut_wide (
    .clk(clk), .rst(rst), .ena(ena_w), .sample(sample_w), .out(out_w)
  );

  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint model_out();
    longint s = 0;
    for (int k = 0; k < 8; k++) s += coef[k] * hist[k];
    return s;
  endfunction

  // One clock edge on the 8-tap filter, then compare against the model.
  task automatic cyc(input string tag, input logic r, input logic e,
                     input int smp);
    rst    = r;
    ena    = e;
    sample = 16'(smp);
    @(posedge clk);
    #1;
    if (r) begin
      for (int k = 0; k < 8; k++) hist[k] = 0;
    end else if (e) begin
      for (int k = 7; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = longint'(smp);
    end
    check(tag, longint'(out), model_out());
  endtask

  initial begin
    int     impulse_exp [10] = '{1, 2, 3, 4, 4, 3, 2, 1, 0, 0};
    longint w_exp;
    for (int k = 0; k < 8; k++) hist[k] = 0;

    cyc("reset0", 1'b1, 1'b1, 32767);
    check("reset0_const", longint'(out), 0);
    cyc("reset1", 1'b1, 1'b1, 32767);
    check("reset1_const", longint'(out), 0);

    for (int i = 0; i < 10; i++) begin
      cyc("impulse", 1'b0, 1'b1, (i == 0) ? 1 : 0);
      check("impulse_const", longint'(out), longint'(impulse_exp[i]));
    end

    for (int i = 0; i < 10; i++) cyc("step_pos", 1'b0, 1'b1, 32767);
    check("step_pos_settle", longint'(out), 655340);
    for (int i = 0; i < 10; i++) cyc("step_neg", 1'b0, 1'b1, -32768);
    check("step_neg_settle", longint'(out), -655360);

    cyc("gate_rst", 1'b1, 1'b0, 0);
    cyc("gate_load", 1'b0, 1'b1, 1);
    cyc("gate_load", 1'b0, 1'b1, 0);
    cyc("gate_load", 1'b0, 1'b1, 0);
    check("gate_at3", longint'(out), 3);
    for (int i = 0; i < 5; i++) begin
      cyc("gate_hold", 1'b0, 1'b0, int'($urandom_range(0, 65535)) - 32768);
      check("gate_hold_const", longint'(out), 3);
    end
    cyc("gate_resume", 1'b0, 1'b1, 0);
    check("gate_resume_const", longint'(out), 4);

    for (int i = 0; i < 10; i++) cyc("mid_step", 1'b0, 1'b1, 32767);
    check("mid_step_settle", longint'(out), 655340);
    cyc("mid_rst", 1'b1, 1'b1, 1234);
    check("mid_rst_const", longint'(out), 0);
    cyc("mid_after", 1'b0, 1'b1, 5);
    check("mid_after_const", longint'(out), 5);

    for (int i = 0; i < 400; i++) begin
      int smp;
      case ($urandom_range(0, 3))
        0:       smp = 32767;
        1:       smp = -32768;
        default: smp = int'($urandom_range(0, 65535)) - 32768;
      endcase
      cyc("random", ($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0), smp);
    end

    cyc("wide_rst", 1'b1, 1'b0, 0);
    check("wide_rst", longint'(out_w), 0);
    rst = 1'b0;
    ena = 1'b0;
    for (int i = 1; i <= 130; i++) begin
      ena_w    = 1'b1;
      sample_w = -16'sd32768;
      @(posedge clk);
      #1;
      w_exp = (i > 128 ? 128 : i) * (longint'(1) << 30);
      check("wide_fill", longint'(out_w), w_exp);
    end
    check("wide_final", longint'(out_w), longint'(1) << 37);
    ena_w = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
